// File: rtl/riscalar_pkg.sv
// Shared constants for the riscalar front end: default datapath widths and the
// canonical NOP used to fill instruction lanes that carry no valid entry.
package riscalar_pkg;

    localparam int RV_INST_WIDTH = 32;
    localparam int RV_PC_WIDTH   = 32;
    localparam logic [31:0] RV_NOP = 32'h0000_0013;

endpackage

// File: rtl/iqueue_mem.sv
// Instruction queue storage: multi-port write, asynchronous multi-port read.
// The array is deliberately left unreset; validity is tracked by the owner.
module iqueue_mem
    import riscalar_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int INST_WIDTH = RV_INST_WIDTH,
    parameter int PC_WIDTH   = RV_PC_WIDTH,
    parameter int ENQ_WIDTH  = 2,
    parameter int DEQ_WIDTH  = 2,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                            clk_in,
    input  logic [ENQ_WIDTH-1:0]            wr_en,
    input  logic [ENQ_WIDTH-1:0][AW-1:0]    wr_addr,
    input  logic [ENQ_WIDTH*INST_WIDTH-1:0] wr_inst,
    input  logic [ENQ_WIDTH*PC_WIDTH-1:0]   wr_pc,
    input  logic [DEQ_WIDTH-1:0][AW-1:0]    rd_addr,
    output logic [DEQ_WIDTH*INST_WIDTH-1:0] rd_inst,
    output logic [DEQ_WIDTH*PC_WIDTH-1:0]   rd_pc
);

    logic [INST_WIDTH-1:0] inst_mem [DEPTH];
    logic [PC_WIDTH-1:0]   pc_mem   [DEPTH];

    // Write addresses are always distinct in a given cycle, so lane order is irrelevant.
    always_ff @(posedge clk_in) begin
        for (int i = 0; i < ENQ_WIDTH; i++) begin
            if (wr_en[i]) begin
                inst_mem[wr_addr[i]] <= wr_inst[i*INST_WIDTH +: INST_WIDTH];
                pc_mem[wr_addr[i]]   <= wr_pc[i*PC_WIDTH +: PC_WIDTH];
            end
        end
    end

    for (genvar i = 0; i < DEQ_WIDTH; i++) begin : g_rd
        assign rd_inst[i*INST_WIDTH +: INST_WIDTH] = inst_mem[rd_addr[i]];
        assign rd_pc[i*PC_WIDTH +: PC_WIDTH]       = pc_mem[rd_addr[i]];
    end

endmodule

// File: rtl/multi_issue_iqueue.sv
// Multi-issue instruction queue: up to ENQ_WIDTH writes and DEQ_WIDTH reads per
// cycle, oldest-first read lanes, flush and async reset clear the pointers only.
module multi_issue_iqueue
    import riscalar_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int INST_WIDTH = RV_INST_WIDTH,
    parameter int PC_WIDTH   = RV_PC_WIDTH,
    parameter int ENQ_WIDTH  = 2,
    parameter int DEQ_WIDTH  = 2
) (
    input  logic                                clk_in,
    input  logic                                rst_n_in,
    input  logic                                flush_in,
    input  logic [ENQ_WIDTH-1:0]                enq_valid_in,
    input  logic [ENQ_WIDTH*INST_WIDTH-1:0]     enq_inst_in,
    input  logic [ENQ_WIDTH*PC_WIDTH-1:0]       enq_pc_in,
    output logic                                enq_ready_out,
    output logic [DEQ_WIDTH-1:0]                deq_valid_out,
    output logic [DEQ_WIDTH*INST_WIDTH-1:0]     deq_inst_out,
    output logic [DEQ_WIDTH*PC_WIDTH-1:0]       deq_pc_out,
    input  logic [$clog2(DEQ_WIDTH+1)-1:0]      deq_count_in,
    output logic [$clog2(DEPTH+1)-1:0]          count_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [AW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] enq_num, enq_acc, deq_lanes, deq_req, deq_num;
    logic          prefix_open;
    logic          enq_fire;

    logic [ENQ_WIDTH-1:0]            wr_en;
    logic [ENQ_WIDTH-1:0][AW-1:0]    wr_addr;
    logic [DEQ_WIDTH-1:0][AW-1:0]    rd_addr;
    logic [DEQ_WIDTH*INST_WIDTH-1:0] rd_inst;
    logic [DEQ_WIDTH*PC_WIDTH-1:0]   rd_pc;

    // Only the contiguous run of valid lanes starting at lane 0 is honoured.
    always_comb begin
        enq_num     = '0;
        prefix_open = 1'b1;
        for (int i = 0; i < ENQ_WIDTH; i++) begin
            if (prefix_open && enq_valid_in[i]) begin
                enq_num = enq_num + CW'(1);
            end else begin
                prefix_open = 1'b0;
            end
        end
    end

    assign enq_ready_out = (count_q <= CW'(DEPTH - ENQ_WIDTH));
    assign enq_fire      = enq_ready_out && !flush_in;
    assign enq_acc       = enq_ready_out ? enq_num : '0;

    assign deq_lanes = (count_q > CW'(DEQ_WIDTH)) ? CW'(DEQ_WIDTH) : count_q;
    assign deq_req   = CW'(deq_count_in);
    assign deq_num   = (deq_req > deq_lanes) ? deq_lanes : deq_req;

    for (genvar i = 0; i < ENQ_WIDTH; i++) begin : g_wr
        assign wr_en[i]   = enq_fire && (CW'(i) < enq_num);
        assign wr_addr[i] = wr_ptr_q + AW'(i);
    end

    // Invalid lanes present a NOP so downstream decode never sees stale words.
    for (genvar i = 0; i < DEQ_WIDTH; i++) begin : g_rd
        assign rd_addr[i]       = rd_ptr_q + AW'(i);
        assign deq_valid_out[i] = (count_q > CW'(i));
        assign deq_inst_out[i*INST_WIDTH +: INST_WIDTH] =
            deq_valid_out[i] ? rd_inst[i*INST_WIDTH +: INST_WIDTH] : INST_WIDTH'(RV_NOP);
        assign deq_pc_out[i*PC_WIDTH +: PC_WIDTH] =
            deq_valid_out[i] ? rd_pc[i*PC_WIDTH +: PC_WIDTH] : '0;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_in) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_q + AW'(deq_num);
            wr_ptr_q <= wr_ptr_q + AW'(enq_acc);
            count_q  <= count_q + enq_acc - deq_num;
        end
    end

    assign count_out = count_q;

    iqueue_mem #(
        .DEPTH      (DEPTH),
        .INST_WIDTH (INST_WIDTH),
        .PC_WIDTH   (PC_WIDTH),
        .ENQ_WIDTH  (ENQ_WIDTH),
        .DEQ_WIDTH  (DEQ_WIDTH),
        .AW         (AW)
    ) u_mem (
        .clk_in  (clk_in),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_inst (enq_inst_in),
        .wr_pc   (enq_pc_in),
        .rd_addr (rd_addr),
        .rd_inst (rd_inst),
        .rd_pc   (rd_pc)
    );

endmodule

// File: doc/multi_issue_iqueue.md
MULTI_ISSUE_IQUEUE -- requirements
Module: multi_issue_iqueue

Interface
REQ-001 SHALL have parameter DEPTH, default 8: entry count; power of two, at least 2*ENQ_WIDTH.
REQ-002 SHALL have parameter INST_WIDTH, default 32: instruction width.
REQ-003 SHALL have parameter PC_WIDTH, default 32: width of the PC tag stored with each instruction.
REQ-004 SHALL have parameter ENQ_WIDTH, default 2: maximum enqueues per cycle.
REQ-005 SHALL have parameter DEQ_WIDTH, default 2: maximum dequeues per cycle.
REQ-006 SHALL have port clk_in, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst_n_in, input, 1 bit: reset, asynchronous assert, active-low.
REQ-008 SHALL have port flush_in, input, 1 bit: discard all entries (mispredict or redirect).
REQ-009 SHALL have port enq_valid_in, input, ENQ_WIDTH bits: per-lane write request.
REQ-010 SHALL have port enq_inst_in, input, ENQ_WIDTH*INST_WIDTH bits: lane-packed instructions.
REQ-011 SHALL have port enq_pc_in, input, ENQ_WIDTH*PC_WIDTH bits: lane-packed PCs.
REQ-012 SHALL have port enq_ready_out, output, 1 bit: free slots are at least ENQ_WIDTH.
REQ-013 SHALL have port deq_valid_out, output, DEQ_WIDTH bits: lane i holds the (i+1)-th oldest entry.
REQ-014 SHALL have port deq_inst_out, output, DEQ_WIDTH*INST_WIDTH bits: oldest-first instructions.
REQ-015 SHALL have port deq_pc_out, output, DEQ_WIDTH*PC_WIDTH bits: oldest-first PCs.
REQ-016 SHALL have port deq_count_in, input, clog2(DEQ_WIDTH+1) bits: number of entries consumed this cycle.
REQ-017 SHALL have port count_out, output, clog2(DEPTH+1) bits: current occupancy.

Function
REQ-018 SHALL treat enq_valid_in as a contiguous prefix from lane 0; any non-prefix pattern is illegal (bench asserts) and only the prefix up to the first 0 is written.
REQ-019 SHALL accept a write only when enq_ready_out=1; accepted lanes go to wr_ptr+i in lane order, all-or-nothing per cycle.
REQ-020 SHALL compute enq_ready_out from current occupancy only; there is no credit for same-cycle dequeue.
REQ-021 SHALL drive deq_valid_out[i] = (count_out > i), with lane data read combinationally from storage at rd_ptr+i.
REQ-022 SHALL clamp deq_count_in to min(deq_count_in, valid lanes) and advance rd_ptr by the clamped amount.
REQ-023 SHALL update occupancy as count + accepted_enq - clamped_deq; simultaneous enqueue and dequeue are legal and never overflow.
REQ-024 SHALL make an entry written in cycle N first visible on deq outputs in cycle N+1; there is no bypass.
REQ-025 SHALL index storage with clog2(DEPTH)-bit pointers that wrap modulo DEPTH; lane offsets also wrap.
REQ-026 SHALL, on flush_in=1, zero rd_ptr, wr_ptr and count at the next edge, ignoring same-cycle enqueue and dequeue; flush has top priority.
REQ-027 SHALL not rely on flush or reset clearing storage contents; deq data is don't-care where deq_valid_out=0.

Reset
REQ-028 SHALL, while rst_n_in=0, force rd_ptr=0, wr_ptr=0 and count=0, giving count_out=0, deq_valid_out=0 and enq_ready_out=1.
REQ-029 SHALL, on reset asserted mid-operation, immediately discard all contents.
REQ-030 SHALL accept the first write at the first rising edge after rst_n_in deasserts.

Structure
REQ-031 SHALL take shared constants (default INST_WIDTH, PC_WIDTH and the NOP encoding 32'h00000013) from package riscalar_pkg.
REQ-032 SHALL place storage in one sub-module, iqueue_mem: DEPTH entries, ENQ_WIDTH write ports, DEQ_WIDTH asynchronous read ports, with no reset on the array.
REQ-033 SHALL keep pointer, count and handshake logic in multi_issue_iqueue.

Verification (DEPTH=8, ENQ_WIDTH=2, DEQ_WIDTH=2)
REQ-034 Scenario: enqueue A,B (PC 0x0,0x4) with deq_count_in=0, then enqueue C -> count_out=3; lane0=A/0x0, lane1=B/0x4.
REQ-035 Scenario: fill to 7 -> enq_ready_out=0; write with enq_valid_in=2'b11 is ignored and count stays 7; deq_count_in=1 -> next cycle count=6, enq_ready_out=1.
REQ-036 Scenario: count=1, enqueue 2 and deq_count_in=2 in the same cycle -> clamped to 1; count=2; oldest order kept.
REQ-037 Scenario: 20 cycles of 2-in/2-out, crossing index 7->0 -> output sequence equals input sequence with no loss or duplicate.
REQ-038 Scenario: count=5, assert flush_in together with enq_valid_in=2'b11 -> next cycle count_out=0, deq_valid_out=0.
REQ-039 Scenario: drop rst_n_in between clock edges with count=4 -> count_out=0 and enq_ready_out=1 before the next edge.
